// File: rtl/ps2_send_pkg.sv
// Shared PS/2 definitions: host-to-device send FSM states, default cycle
// counts at 50 MHz and the frame parity helper.
package ps2_send_pkg;

    typedef enum logic [2:0] {
        PS2_ST_IDLE      = 3'd0,
        PS2_ST_INHIBIT   = 3'd1,
        PS2_ST_START     = 3'd2,
        PS2_ST_BITS      = 3'd3,
        PS2_ST_WAIT_IDLE = 3'd4,
        PS2_ST_DONE      = 3'd5,
        PS2_ST_ERR       = 3'd6
    } ps2SendState_t;

    // 100 us clock inhibit, 15 ms ACK timeout, 25 us line filter (50 MHz)
    localparam int PS2_INHIBIT_CYCLES = 5000;
    localparam int PS2_TIMEOUT_CYCLES = 750000;
    localparam int PS2_FILTER_CYCLES  = 1250;

    // Edge counter values seen when the 10th / 11th falling edge arrives
    localparam logic [3:0] PS2_EDGE_STOP = 4'd9;
    localparam logic [3:0] PS2_EDGE_ACK  = 4'd10;

    // Odd parity bit for a data byte
    function automatic logic oddParity(input logic [7:0] data);
        return ~^data;
    endfunction

endpackage

// File: rtl/ps2_send_chattering_canceller_50mhz_25us.sv
// Line filter: each bit is synchronised, then only accepted once it has held
// a new level for P_STABLE_CYCLES consecutive clocks. Idle level is high.
module chattering_canceller_50mhz_25us #(
    parameter int P_WIDTH         = 2,
    parameter int P_STABLE_CYCLES = 1250
)(
    input  logic               iCLOCK,
    input  logic               inRESET,
    input  logic [P_WIDTH-1:0] iDATA,
    output logic [P_WIDTH-1:0] oDATA
);
    localparam int CNT_W = $clog2(P_STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(P_STABLE_CYCLES - 1);

    logic [P_WIDTH-1:0] sync1_r;
    logic [P_WIDTH-1:0] sync2_r;

    // Two-flop synchroniser for the asynchronous line levels
    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            sync1_r <= {P_WIDTH{1'b1}};
            sync2_r <= {P_WIDTH{1'b1}};
        end else begin
            sync1_r <= iDATA;
            sync2_r <= sync1_r;
        end
    end

    genvar i;
    generate
        for (i = 0; i < P_WIDTH; i++) begin : gBit
            logic [CNT_W-1:0] cnt_r;
            logic             level_r;

            // Adopt a new level only after it has been stable long enough
            always_ff @(posedge iCLOCK or negedge inRESET) begin
                if (!inRESET) begin
                    cnt_r   <= CNT_W'(0);
                    level_r <= 1'b1;
                end else if (sync2_r[i] == level_r) begin
                    cnt_r   <= CNT_W'(0);
                end else if (cnt_r == CNT_LAST) begin
                    cnt_r   <= CNT_W'(0);
                    level_r <= sync2_r[i];
                end else begin
                    cnt_r   <= cnt_r + CNT_W'(1);
                end
            end

            assign oDATA[i] = level_r;
        end
    endgenerate

endmodule

// File: rtl/ps2_send.sv
// PS/2 host-to-device byte transmitter. Drives open-drain enables only; the
// enclosing top level turns the enables into 0/Z on the physical lines.
module ps2_send
    import ps2_send_pkg::*;
#(
    parameter int P_INHIBIT_CYCLES = PS2_INHIBIT_CYCLES,
    parameter int P_TIMEOUT_CYCLES = PS2_TIMEOUT_CYCLES,
    parameter int P_FILTER_CYCLES  = PS2_FILTER_CYCLES
)(
    input  logic       iCLOCK,
    input  logic       inRESET,
    input  logic       iPS2MOD_REQ,
    input  logic [7:0] iPS2MOD_DATA,
    output logic       oPS2MOD_BUSY,
    output logic       oPS2MOD_DONE,
    output logic       oPS2MOD_ERR,
    input  logic       iPS2_CLOCK,
    input  logic       iPS2_DATA,
    output logic       oPS2_CLOCK_OE,
    output logic       oPS2_DATA_OE
);
    localparam int INH_W = $clog2(P_INHIBIT_CYCLES + 1);
    localparam int TO_W  = $clog2(P_TIMEOUT_CYCLES + 1);
    localparam logic [INH_W-1:0] INH_LAST   = INH_W'(P_INHIBIT_CYCLES - 1);
    localparam logic [INH_W-1:0] INH_PENULT = INH_W'(P_INHIBIT_CYCLES - 2);
    localparam logic [TO_W-1:0]  TO_LAST    = TO_W'(P_TIMEOUT_CYCLES - 1);

    ps2SendState_t    state_r, state_s;
    logic [INH_W-1:0] inhibitCnt_r, inhibitCnt_s;
    logic [TO_W-1:0]  timeoutCnt_r, timeoutCnt_s;
    logic [3:0]       edgeCnt_r, edgeCnt_s;
    logic [8:0]       frame_r, frame_s;     // {parity, data}, frozen while busy
    logic             clockOe_r, clockOe_s;
    logic             dataOe_r, dataOe_s;
    logic             busy_r, busy_s;
    logic             done_r, done_s;
    logic             err_r, err_s;
    logic             prevClk_r;
    logic             ps2Clk_s, ps2Data_s, fall_s;

    chattering_canceller_50mhz_25us #(
        .P_WIDTH         (2),
        .P_STABLE_CYCLES (P_FILTER_CYCLES)
    ) uFilter (
        .iCLOCK  (iCLOCK),
        .inRESET (inRESET),
        .iDATA   ({iPS2_CLOCK, iPS2_DATA}),
        .oDATA   ({ps2Clk_s, ps2Data_s})
    );

    assign fall_s = prevClk_r & ~ps2Clk_s;

    // Next-state and next-output logic; outputs are registered copies
    always_comb begin
        state_s      = state_r;
        inhibitCnt_s = inhibitCnt_r;
        timeoutCnt_s = timeoutCnt_r;
        edgeCnt_s    = edgeCnt_r;
        frame_s      = frame_r;
        clockOe_s    = 1'b0;
        dataOe_s     = 1'b0;
        busy_s       = 1'b1;
        done_s       = 1'b0;
        err_s        = 1'b0;
        case (state_r)
            PS2_ST_IDLE: begin
                if (iPS2MOD_REQ) begin
                    frame_s      = {oddParity(iPS2MOD_DATA), iPS2MOD_DATA};
                    inhibitCnt_s = INH_W'(0);
                    timeoutCnt_s = TO_W'(0);
                    edgeCnt_s    = 4'd0;
                    state_s      = PS2_ST_INHIBIT;
                    clockOe_s    = 1'b1;
                    dataOe_s     = (INH_LAST == INH_W'(0));
                end else begin
                    busy_s = 1'b0;
                end
            end
            PS2_ST_INHIBIT: begin
                if (inhibitCnt_r == INH_LAST) begin
                    state_s  = PS2_ST_START;
                    dataOe_s = 1'b1;
                end else begin
                    inhibitCnt_s = inhibitCnt_r + INH_W'(1);
                    clockOe_s    = 1'b1;
                    // data goes low in the final inhibit cycle
                    dataOe_s     = (inhibitCnt_r == INH_PENULT);
                end
            end
            PS2_ST_START: begin
                timeoutCnt_s = timeoutCnt_r + TO_W'(1);
                dataOe_s     = 1'b1;
                state_s      = PS2_ST_BITS;
            end
            PS2_ST_BITS: begin
                timeoutCnt_s = timeoutCnt_r + TO_W'(1);
                dataOe_s     = dataOe_r;
                if (timeoutCnt_r == TO_LAST) begin
                    state_s  = PS2_ST_ERR;
                    err_s    = 1'b1;
                    dataOe_s = 1'b0;
                end else if (fall_s) begin
                    edgeCnt_s = edgeCnt_r + 4'd1;
                    if (edgeCnt_r < PS2_EDGE_STOP) begin
                        // edges 1..9: data LSB first, then parity
                        dataOe_s = ~frame_r[edgeCnt_r];
                    end else if (edgeCnt_r == PS2_EDGE_STOP) begin
                        dataOe_s = 1'b0;
                    end else if (edgeCnt_r == PS2_EDGE_ACK) begin
                        dataOe_s = 1'b0;
                        if (ps2Data_s) begin
                            state_s = PS2_ST_ERR;
                            err_s   = 1'b1;
                        end else begin
                            state_s = PS2_ST_WAIT_IDLE;
                        end
                    end else begin
                        edgeCnt_s = edgeCnt_r;
                        state_s   = PS2_ST_ERR;
                        err_s     = 1'b1;
                        dataOe_s  = 1'b0;
                    end
                end else begin
                    edgeCnt_s = edgeCnt_r;
                end
            end
            PS2_ST_WAIT_IDLE: begin
                timeoutCnt_s = timeoutCnt_r + TO_W'(1);
                if (timeoutCnt_r == TO_LAST) begin
                    state_s = PS2_ST_ERR;
                    err_s   = 1'b1;
                end else if (ps2Clk_s && ps2Data_s) begin
                    state_s = PS2_ST_DONE;
                    done_s  = 1'b1;
                end else begin
                    state_s = PS2_ST_WAIT_IDLE;
                end
            end
            PS2_ST_DONE, PS2_ST_ERR: begin
                state_s = PS2_ST_IDLE;
                busy_s  = 1'b0;
            end
            default: begin
                state_s = PS2_ST_IDLE;
                busy_s  = 1'b0;
            end
        endcase
    end

    // State, counters, frame and output registers
    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            state_r      <= PS2_ST_IDLE;
            inhibitCnt_r <= INH_W'(0);
            timeoutCnt_r <= TO_W'(0);
            edgeCnt_r    <= 4'd0;
            frame_r      <= 9'd0;
            clockOe_r    <= 1'b0;
            dataOe_r     <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            err_r        <= 1'b0;
            prevClk_r    <= 1'b1;
        end else begin
            state_r      <= state_s;
            inhibitCnt_r <= inhibitCnt_s;
            timeoutCnt_r <= timeoutCnt_s;
            edgeCnt_r    <= edgeCnt_s;
            frame_r      <= frame_s;
            clockOe_r    <= clockOe_s;
            dataOe_r     <= dataOe_s;
            busy_r       <= busy_s;
            done_r       <= done_s;
            err_r        <= err_s;
            prevClk_r    <= ps2Clk_s;
        end
    end

    assign oPS2_CLOCK_OE = clockOe_r;
    assign oPS2_DATA_OE  = dataOe_r;
    assign oPS2MOD_BUSY  = busy_r;
    assign oPS2MOD_DONE  = done_r;
    assign oPS2MOD_ERR   = err_r;

endmodule

// File: tb/tb_ps2_send.sv
// Directed bench for ps2_send with a behavioural PS/2 device on open-drain lines.
module tb_ps2_send;
    localparam int INH = 40;
    localparam int TMO = 1500;
    localparam int FLT = 4;
    localparam int H   = 25;   // device clock half period in iCLOCK cycles

    logic       iCLOCK  = 1'b0;
    logic       inRESET = 1'b0;
    logic       req     = 1'b0;
    logic [7:0] data    = 8'h00;
    logic       busy, done, err, clockOe, dataOe;
    logic       bfmClkLow  = 1'b0;
    logic       bfmDataLow = 1'b0;
    logic       ps2ClkLine, ps2DataLine;

    int doneCnt = 0;
    int errCnt  = 0;
    int bothCnt = 0;
    int nVec    = 0;
    int nMis    = 0;

    typedef struct {
        logic [7:0]  data;
        logic        ack;
        logic        midReq;
        logic [10:0] expSeq;   // {stop, parity, d7..d0, start}
        int          expDone;
        int          expErr;
    } vec_t;

    vec_t vecs[6];

    assign ps2ClkLine  = ~(clockOe | bfmClkLow);
    assign ps2DataLine = ~(dataOe | bfmDataLow);

    ps2_send #(
        .P_INHIBIT_CYCLES (INH),
        .P_TIMEOUT_CYCLES (TMO),
        .P_FILTER_CYCLES  (FLT)
    ) dut (
        .iCLOCK        (iCLOCK),
        .inRESET       (inRESET),
        .iPS2MOD_REQ   (req),
        .iPS2MOD_DATA  (data),
        .oPS2MOD_BUSY  (busy),
        .oPS2MOD_DONE  (done),
        .oPS2MOD_ERR   (err),
        .iPS2_CLOCK    (ps2ClkLine),
        .iPS2_DATA     (ps2DataLine),
        .oPS2_CLOCK_OE (clockOe),
        .oPS2_DATA_OE  (dataOe)
    );

    always #10 iCLOCK = ~iCLOCK;

    // Pulse counters
    always @(negedge iCLOCK) begin
        if (done) doneCnt <= doneCnt + 1;
        if (err) errCnt <= errCnt + 1;
        if (done && err) bothCnt <= bothCnt + 1;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nVec++;
        if (act !== exp) begin
            nMis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_start(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < INH + 50 && !ok; k++) begin
            @(negedge iCLOCK);
            if (!clockOe && dataOe && busy) ok = 1'b1;
        end
    endtask

    task automatic run_frame(input int idx);
        vec_t        v;
        logic [10:0] seq;
        bit          ok;
        int          d0, e0, busyAfter;
        v  = vecs[idx];
        d0 = doneCnt;
        e0 = errCnt;
        seq = 11'd0;
        data = v.data;
        req  = 1'b1;
        @(negedge iCLOCK);
        req  = 1'b0;
        data = ~v.data;
        check("busy_on_accept", busy, 1);
        wait_start(ok);
        check("start_seen", ok, 1);
        repeat (H) @(negedge iCLOCK);
        seq[0] = ps2DataLine;
        for (int i = 1; i <= 10; i++) begin
            bfmClkLow = 1'b1;
            if (v.midReq && i == 5) begin
                req  = 1'b1;
                data = 8'h5A;
            end
            @(negedge iCLOCK);
            req = 1'b0;
            repeat (H - 1) @(negedge iCLOCK);
            seq[i] = ps2DataLine;
            bfmClkLow = 1'b0;
            if (i == 10 && v.ack) bfmDataLow = 1'b1;
            repeat (H) @(negedge iCLOCK);
        end
        bfmClkLow = 1'b1;
        repeat (H) @(negedge iCLOCK);
        bfmClkLow = 1'b0;
        repeat (H) @(negedge iCLOCK);
        bfmDataLow = 1'b0;
        ok = 1'b0;
        for (int k = 0; k < 4 * H + 50 && !ok; k++) begin
            @(negedge iCLOCK);
            if (!busy) ok = 1'b1;
        end
        check("frame_end", ok, 1);
        check("line_sequence", seq, v.expSeq);
        check("done_pulses", doneCnt - d0, v.expDone);
        check("err_pulses", errCnt - e0, v.expErr);
        busyAfter = 0;
        repeat (30) begin
            @(negedge iCLOCK);
            if (busy) busyAfter++;
        end
        check("no_requeue", busyAfter, 0);
    endtask

    initial begin
        bit ok;
        int inhCycles, firstDoe, cycles, d0, e0, busyAfter;

        vecs[0] = '{8'hED, 1'b1, 1'b0, 11'b11_1110_1101_0, 1, 0};
        vecs[1] = '{8'h00, 1'b1, 1'b0, 11'b11_0000_0000_0, 1, 0};
        vecs[2] = '{8'hFF, 1'b1, 1'b0, 11'b11_1111_1111_0, 1, 0};
        vecs[3] = '{8'h01, 1'b1, 1'b0, 11'b10_0000_0001_0, 1, 0};
        vecs[4] = '{8'hA5, 1'b0, 1'b1, 11'b11_1010_0101_0, 0, 1};
        vecs[5] = '{8'h07, 1'b1, 1'b0, 11'b10_0000_0111_0, 1, 0};

        // reset state
        repeat (4) @(negedge iCLOCK);
        check("reset_outputs", {clockOe, dataOe, busy, done, err}, 5'b00000);
        inRESET = 1'b1;
        repeat (20) @(negedge iCLOCK);
        check("post_reset_outputs", {clockOe, dataOe, busy, done, err}, 5'b00000);
        check("post_reset_pulses", doneCnt + errCnt, 0);

        // table-driven frames
        for (int i = 0; i < 6; i++) run_frame(i);

        // inhibit length, then a device that never clocks -> timeout
        d0 = doneCnt;
        data = 8'h55;
        req  = 1'b1;
        @(negedge iCLOCK);
        req = 1'b0;
        inhCycles = 0;
        firstDoe  = -1;
        while (clockOe && inhCycles < INH + 50) begin
            if (dataOe && firstDoe < 0) firstDoe = inhCycles;
            inhCycles++;
            @(negedge iCLOCK);
        end
        check("inhibit_length", inhCycles, INH);
        check("inhibit_data_oe_cycle", firstDoe, INH - 1);
        check("start_oe", {clockOe, dataOe}, 2'b01);
        cycles = 0;
        while (!err && cycles < TMO + 100) begin
            @(negedge iCLOCK);
            cycles++;
        end
        check("timeout_cycles", cycles, TMO);
        check("timeout_release", {clockOe, dataOe, done}, 3'b000);
        @(negedge iCLOCK);
        check("timeout_busy_next", busy, 0);
        check("timeout_no_done", doneCnt - d0, 0);

        // reset mid-frame after edge 5
        data = 8'hED;
        req  = 1'b1;
        @(negedge iCLOCK);
        req = 1'b0;
        wait_start(ok);
        check("rst_start_seen", ok, 1);
        repeat (H) @(negedge iCLOCK);
        for (int i = 0; i < 5; i++) begin
            bfmClkLow = 1'b1;
            repeat (H) @(negedge iCLOCK);
            bfmClkLow = 1'b0;
            repeat (H) @(negedge iCLOCK);
        end
        check("rst_before", {clockOe, dataOe, busy}, 3'b011);
        inRESET = 1'b0;
        #1;
        check("rst_midframe_outputs", {clockOe, dataOe, busy, done, err}, 5'b00000);
        repeat (3) @(negedge iCLOCK);
        inRESET = 1'b1;
        d0 = doneCnt;
        e0 = errCnt;
        busyAfter = 0;
        repeat (50) begin
            @(negedge iCLOCK);
            if (busy || clockOe || dataOe) busyAfter++;
        end
        check("rst_quiet", busyAfter, 0);
        check("rst_no_pulses", (doneCnt - d0) + (errCnt - e0), 0);
        run_frame(0);

        check("done_err_exclusive", bothCnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

endmodule
